ddr_rd_return_buf: RTL

- Read-return stage directly downstream of the DDR data path.
- Captures each 128-bit read burst, qualified by its one-cycle data-valid strobe, into a small FIFO.
- Unpacks each burst into four 32-bit words and delivers them to the user side (HDR pipeline / frame writer) over a valid/ready handshake.
- The data path has no backpressure, so this block supplies the almost-full indication the command scheduler uses to throttle new reads.

---
 rtl/ddr_pkg.sv | 15 +
 rtl/ddr_rd_return_buf_if.sv | 31 +++
 rtl/rd_burst_fifo.sv | 73 +++++++
 rtl/ddr_rd_return_buf.sv | 125 ++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared widths and unpacker state encoding for the DDR read-return stage.
package ddr_pkg;

   localparam int BURST_W         = 128;
   localparam int WORD_W          = 32;
   localparam int WORDS_PER_BURST = 4;
   localparam int IDX_W           = $clog2(WORDS_PER_BURST);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } unpack_state_e;

endpackage

// File: rtl/ddr_rd_return_buf_if.sv
// Burst-in / word-out signal bundle between the DDR data path, the return buffer and its consumer.
interface ddr_rd_return_buf_if;
   import ddr_pkg::*;

   logic [BURST_W-1:0] burst_data;
   logic               burst_valid;
   logic [WORD_W-1:0]  out_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_last;

   // slave: the return buffer itself; master: data path plus consumer driving it
   modport slave (
      input  burst_data,
      input  burst_valid,
      input  out_ready,
      output out_data,
      output out_valid,
      output out_last
   );

   modport master (
      output burst_data,
      output burst_valid,
      output out_ready,
      input  out_data,
      input  out_valid,
      input  out_last
   );

endinterface

// File: rtl/rd_burst_fifo.sv
// Burst-wide synchronous FIFO; a write to a full FIFO is accepted when the head is popped in the same cycle.
module rd_burst_fifo
   import ddr_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_req_i,
   input  logic [BURST_W-1:0]     wr_data_i,
   input  logic                   pop_i,
   output logic [BURST_W-1:0]     rd_data_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic [$clog2(DEPTH):0] level_d_o,
   output logic                   empty_o,
   output logic                   wr_en_o,
   output logic                   drop_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [BURST_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [LVL_W-1:0]   level_q;
   logic [LVL_W-1:0]   level_d;
   logic               full;
   logic               wr_en;

   assign full  = (level_q == LVL_W'(DEPTH));
   assign wr_en = wr_req_i & (~full | pop_i);

   always_comb begin
      level_d = level_q;
      case ({wr_en, pop_i})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Pointers are PTR_W wide, so wrap modulo DEPTH comes for free.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign level_o   = level_q;
   assign level_d_o = level_d;
   assign empty_o   = (level_q == '0);
   assign wr_en_o   = wr_en;
   assign drop_o    = wr_req_i & full & ~pop_i;

endmodule

// File: rtl/ddr_rd_return_buf.sv
// DDR read-return buffer: queues 128-bit bursts and unpacks them into 32-bit words for the consumer.
// Define RD_RETURN_DROP_CNT_EN to add the saturating drop_cnt output.
module ddr_rd_return_buf
   import ddr_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   ddr_rd_return_buf_if.slave      bus,
   output logic                    rd_almost_full,
   output logic                    rd_empty,
   output logic                    overflow,
   output logic [$clog2(DEPTH):0]  level
`ifdef RD_RETURN_DROP_CNT_EN
   ,
   output logic [7:0]              drop_cnt
`endif
);

   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BURST - 1);

   unpack_state_e      state_q, state_d;
   logic [BURST_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]   word_idx_q, word_idx_d;
   logic               af_q;
   logic               ovf_q;

   logic [BURST_W-1:0] head_data;
   logic [LVL_W-1:0]   level_d;
   logic               fifo_empty;
   logic               wr_en;
   logic               drop;
   logic               hs;
   logic               pop;

   assign hs  = (state_q == SEND) & bus.out_ready;
   assign pop = hs & (word_idx_q == LAST_IDX);

   rd_burst_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_req_i  (bus.burst_valid),
      .wr_data_i (bus.burst_data),
      .pop_i     (pop),
      .rd_data_o (head_data),
      .level_o   (level),
      .level_d_o (level_d),
      .empty_o   (fifo_empty),
      .wr_en_o   (wr_en),
      .drop_o    (drop)
   );

   // Looking at this cycle's write lets an empty FIFO reach SEND two cycles after the strobe.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      word_idx_d = word_idx_q;
      case (state_q)
         IDLE: begin
            if (!fifo_empty || wr_en) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            shift_d    = head_data;
            word_idx_d = '0;
            state_d    = SEND;
         end
         SEND: begin
            if (hs) begin
               shift_d    = shift_q << WORD_W;
               word_idx_d = word_idx_q + 1'b1;
               if (word_idx_q == LAST_IDX) begin
                  state_d = ((level > LVL_W'(1)) || wr_en) ? LOAD : IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         word_idx_q <= '0;
         af_q       <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         word_idx_q <= word_idx_d;
         af_q       <= (level_d >= LVL_W'(AF_LEVEL));
         ovf_q      <= ovf_q | drop;
      end
   end

`ifdef RD_RETURN_DROP_CNT_EN
   logic [7:0] drop_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

   assign bus.out_valid = (state_q == SEND);
   assign bus.out_data  = shift_q[BURST_W-1 -: WORD_W];
   assign bus.out_last  = (state_q == SEND) & (word_idx_q == LAST_IDX);

   assign rd_almost_full = af_q;
   assign overflow       = ovf_q;
   assign rd_empty       = fifo_empty & (state_q == IDLE);

endmodule
